load_writeback_unit: RTL and testbench
======================================

Name: load_writeback_unit

Overview:
- Final pipeline stage. Sits directly upstream of the register file and drives its write port (write enable, destination address, write data).
- Accepts one retiring instruction at a time: either an ALU result or a load.
- For loads: issues a word read on the data bus, waits for the response, then aligns and sign/zero-extends the data before writeback.
- Non-load results are written back one cycle after acceptance.

Parameters:
- XLEN, 32, data/address width; matches word_t.
- RADDR_W, 5, register address width; matches reg_addr_t.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  unit can accept an instruction this cycle.
- in_is_load  in  1  1 = load; in_result is the effective address.
- in_funct3  in  3  load size/sign code (RV32I encoding).
- in_rd_addr  in  RADDR_W  destination register.
- in_result  in  XLEN  ALU result or load effective address.
- mem_req_valid  out  1  data bus read request.
- mem_req_ready  in  1  bus accepts request.
- mem_req_addr  out  XLEN  word-aligned address; bits [1:0] = 0.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  XLEN  read word.
- rf_write_enable  out  1  register file write strobe.
- rf_rd_addr  out  RADDR_W  register file write address.
- rf_rd_data  out  XLEN  register file write data.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; all registered outputs = 0 (mem_req_valid, mem_req_addr, rf_write_enable, rf_rd_addr, rf_rd_data).
- Reset mid-load aborts the transaction. A late mem_rsp_valid after reset is ignored.
- FSM states: IDLE, REQ, WAIT, WB.
- in_ready is combinational: 1 in IDLE and WB, 0 in REQ and WAIT. Acceptance = in_valid & in_ready.
- Acceptance of a non-load:
  - Next state = WB.
  - rd_addr and result are latched.
  - rf_write_enable = 1 for exactly the following cycle; latency is 1 cycle.
- Acceptance of a load:
  - Next state = REQ.
  - Latched: rd_addr, funct3, offset = in_result[1:0], mem_req_addr = {in_result[31:2], 2'b00}.
- REQ: mem_req_valid = 1 and address held stable until mem_req_ready = 1. Then next state = WAIT and mem_req_valid drops the following cycle.
- WAIT: idle until mem_rsp_valid = 1. Then the extended data is latched into rf_rd_data and next state = WB. mem_rsp_valid in any other state is ignored. A response is never expected in the same cycle as the request handshake.
- WB: rf_write_enable = 1 for this single cycle. Next state:
  - REQ if a load is accepted this cycle;
  - WB if a non-load is accepted (back-to-back ALU writeback, one per cycle);
  - otherwise IDLE.
- x0 writes: rf_write_enable is forced 0 whenever the latched rd_addr = 0. A load to x0 still performs the bus access.
- Load extraction, with shift = 8*offset:
  - 000 LB: sign-extend byte [7:0] of (data >> shift).
  - 100 LBU: zero-extend that byte.
  - 001 LH: sign-extend half [15:0] of (data >> 16*offset[1]).
  - 101 LHU: zero-extend that half.
  - 010 LW and all other codes (011, 110, 111): full word.
- Misaligned half/word accesses are handled by the optional feature below; without it, low offset bits are ignored as listed there.
- busy = (state != IDLE).

Optional Feature:
- Macro: WB_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misaligned_err (1 bit, reset 0).
  - An accepted load is misaligned if it is LH/LHU with offset[0] = 1, or LW with offset != 0.
  - A misaligned load issues no bus request and performs no register write (rf_write_enable stays 0).
  - misaligned_err pulses 1 for one cycle, the cycle after acceptance; the state goes to IDLE.
- Undefined:
  - No port.
  - Halfword uses offset[1] only; word ignores offset.
  - The load always completes normally.

Test Plan:
- ALU back-to-back: accept rd=5/0x1234 then rd=6/0xDEADBEEF on consecutive cycles -> rf_write_enable high two consecutive cycles, writing 0x1234 to x5, then 0xDEADBEEF to x6; in_ready stays 1.
- LB sign: funct3=000, addr 0x103, rd=7, rsp 0x80FFFFFF after 3 wait cycles -> rf_rd_data = 0xFFFFFF80, written one cycle after rsp; mem_req_addr = 0x100.
- LHU/LH: addr 0x202, rsp 0x8001AAAA -> LHU writes 0x00008001, LH writes 0xFFFF8001.
- Bus stall: mem_req_ready low 4 cycles -> mem_req_valid and address stable throughout, in_ready = 0, busy = 1; exactly one request handshake.
- x0 and reset: load to rd=0 -> bus access occurs, rf_write_enable never 1. Assert rst_n = 0 while in WAIT -> all outputs 0 immediately, then a late mem_rsp_valid produces no write.
- With WB_MISALIGN_TRAP_EN: LW at 0x101 -> no mem_req_valid, misaligned_err = 1 for one cycle, no write. Without the macro: the same load reads 0x100 and writes the full word.

Source files
------------

// File: rtl/load_writeback_unit.sv
// Final pipeline stage: ALU result / load writeback into the register file write port.
// Optional macro WB_MISALIGN_TRAP_EN adds misaligned_err and suppresses misaligned loads.
module load_writeback_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_is_load,
    input  logic [2:0]         in_funct3,
    input  logic [RADDR_W-1:0] in_rd_addr,
    input  logic [XLEN-1:0]    in_result,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [XLEN-1:0]    mem_req_addr,
    input  logic               mem_rsp_valid,
    input  logic [XLEN-1:0]    mem_rsp_data,
    output logic               rf_write_enable,
    output logic [RADDR_W-1:0] rf_rd_addr,
    output logic [XLEN-1:0]    rf_rd_data,
    output logic               busy
`ifdef WB_MISALIGN_TRAP_EN
    ,
    output logic               misaligned_err
`endif
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StWb} state_e;

    state_e             state_q, state_d;
    logic [2:0]         funct3_q;
    logic [1:0]         offset_q;
    logic               accept;
    logic               load_mis;
    logic [RADDR_W-1:0] rd_next;
    logic [XLEN-1:0]    shifted;
    logic [15:0]        half;
    logic [XLEN-1:0]    load_data;

    always_comb begin
        in_ready = (state_q == StIdle) || (state_q == StWb);
        accept   = in_valid && in_ready;
`ifdef WB_MISALIGN_TRAP_EN
        load_mis = in_is_load &&
                   (((in_funct3[1:0] == 2'b01) && in_result[0]) ||
                    ((in_funct3 == 3'b010) && (in_result[1:0] != 2'b00)));
`else
        load_mis = 1'b0;
`endif
        state_d = state_q;
        unique case (state_q)
            StIdle, StWb: begin
                if (accept) begin
                    if (in_is_load) state_d = load_mis ? StIdle : StReq;
                    else            state_d = StWb;
                end else begin
                    state_d = StIdle;
                end
            end
            StReq:   if (mem_req_ready) state_d = StWait;
            StWait:  if (mem_rsp_valid) state_d = StWb;
            default: state_d = StIdle;
        endcase
        // Destination seen by the write strobe in the cycle after this one.
        rd_next = accept ? in_rd_addr : rf_rd_addr;
    end

    always_comb begin
        shifted = mem_rsp_data >> {offset_q, 3'b000};
        half    = offset_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
        case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b001:  load_data = {{(XLEN-16){half[15]}}, half};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half};
            default: load_data = mem_rsp_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            funct3_q        <= 3'b000;
            offset_q        <= 2'b00;
            mem_req_valid   <= 1'b0;
            mem_req_addr    <= '0;
            rf_write_enable <= 1'b0;
            rf_rd_addr      <= '0;
            rf_rd_data      <= '0;
        end else begin
            state_q         <= state_d;
            mem_req_valid   <= (state_d == StReq);
            rf_write_enable <= (state_d == StWb) && (rd_next != '0);
            if (accept) begin
                rf_rd_addr <= in_rd_addr;
                if (in_is_load) begin
                    funct3_q     <= in_funct3;
                    offset_q     <= in_result[1:0];
                    mem_req_addr <= {in_result[XLEN-1:2], 2'b00};
                end else begin
                    rf_rd_data <= in_result;
                end
            end
            if ((state_q == StWait) && mem_rsp_valid) rf_rd_data <= load_data;
        end
    end

`ifdef WB_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misaligned_err <= 1'b0;
        else        misaligned_err <= accept && load_mis;
    end
`endif

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_load_writeback_unit.sv
// Self-checking bench for load_writeback_unit: vector table, random loads/ALU ops, corner sequences.
module tb_load_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_funct3 = 3'b000;
    logic [4:0]  in_rd_addr = 5'd0;
    logic [31:0] in_result = 32'd0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'd0;
    logic        rf_write_enable;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        busy;
`ifdef WB_MISALIGN_TRAP_EN
    logic        misaligned_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_writeback_unit #(.XLEN(32), .RADDR_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_is_load      (in_is_load),
        .in_funct3       (in_funct3),
        .in_rd_addr      (in_rd_addr),
        .in_result       (in_result),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .rf_write_enable (rf_write_enable),
        .rf_rd_addr      (rf_rd_addr),
        .rf_rd_data      (rf_rd_data),
        .busy            (busy)
`ifdef WB_MISALIGN_TRAP_EN
        ,
        .misaligned_err  (misaligned_err)
`endif
    );

    typedef struct {
        bit        is_load;
        bit [2:0]  f3;
        bit [4:0]  rd;
        bit [31:0] res;
        bit [31:0] rsp;
        int        stall;
        int        wcyc;
        bit        we;
        bit [31:0] data;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference: extract by byte/half position of the address, then extend.
    function automatic bit [31:0] ref_load(input bit [2:0] f3, input bit [31:0] addr,
                                           input bit [31:0] data);
        bit [31:0] b;
        bit [31:0] h;
        int        off;
        off = int'(addr % 4);
        b = (data >> (8 * off)) & 32'hFF;
        h = (data >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return data;
        endcase
    endfunction

    function automatic bit is_mis(input bit is_load, input bit [2:0] f3, input bit [31:0] a);
`ifdef WB_MISALIGN_TRAP_EN
        bit [31:0] off;
        off = a % 4;
        return is_load && (((f3 == 3'd1 || f3 == 3'd5) && (off % 2 == 1)) ||
                           (f3 == 3'd2 && off != 0));
`else
        return 1'b0;
`endif
    endfunction

    // Drives one instruction through the unit and checks its writeback.
    task automatic run_txn(input string tag, input bit is_load, input bit [2:0] f3,
                           input bit [4:0] rd, input bit [31:0] res, input bit [31:0] rsp,
                           input int stall, input int wcyc, input bit exp_we,
                           input bit [31:0] exp_data);
        int n;
        bit mis;
        mis = is_mis(is_load, f3, res);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_is_load = is_load;
        in_funct3 = f3;
        in_rd_addr = rd;
        in_result = res;
        @(negedge clk);
        in_valid = 1'b0;
        if (mis) begin
`ifdef WB_MISALIGN_TRAP_EN
            chk({tag, ".mis_err"}, misaligned_err, 1);
            chk({tag, ".mis_noreq"}, mem_req_valid, 0);
            chk({tag, ".mis_nowe"}, rf_write_enable, 0);
            chk({tag, ".mis_idle"}, busy, 0);
            @(negedge clk);
            chk({tag, ".mis_pulse"}, misaligned_err, 0);
            chk({tag, ".mis_nowe2"}, rf_write_enable, 0);
`endif
            return;
        end
        if (is_load) begin
            for (int i = 0; i < stall; i++) begin
                chk({tag, ".stall_valid"}, mem_req_valid, 1);
                chk({tag, ".stall_addr"}, mem_req_addr, res & 32'hFFFF_FFFC);
                chk({tag, ".stall_ready"}, in_ready, 0);
                chk({tag, ".stall_busy"}, busy, 1);
                @(negedge clk);
            end
            chk({tag, ".req_valid"}, mem_req_valid, 1);
            chk({tag, ".req_addr"}, mem_req_addr, res & 32'hFFFF_FFFC);
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            chk({tag, ".req_drop"}, mem_req_valid, 0);
            for (int i = 0; i < wcyc; i++) begin
                chk({tag, ".wait_nowe"}, rf_write_enable, 0);
                @(negedge clk);
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data = rsp;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rsp_data = 32'hX5A5_5A5A;
        end
        chk({tag, ".we"}, rf_write_enable, exp_we);
        chk({tag, ".rd"}, rf_rd_addr, rd);
        chk({tag, ".data"}, rf_rd_data, exp_data);
    endtask

    initial begin
        tbl[0]  = '{1, 3'd0, 5'd7,  32'h0000_0103, 32'h80FF_FFFF, 0, 3, 1, 32'hFFFF_FF80};
        tbl[1]  = '{1, 3'd5, 5'd8,  32'h0000_0202, 32'h8001_AAAA, 0, 1, 1, 32'h0000_8001};
        tbl[2]  = '{1, 3'd1, 5'd9,  32'h0000_0202, 32'h8001_AAAA, 1, 0, 1, 32'hFFFF_8001};
        tbl[3]  = '{1, 3'd4, 5'd10, 32'h0000_0101, 32'h1234_5678, 0, 0, 1, 32'h0000_0056};
        tbl[4]  = '{1, 3'd0, 5'd11, 32'h0000_0101, 32'h1234_F678, 0, 2, 1, 32'hFFFF_FFF6};
        tbl[5]  = '{1, 3'd1, 5'd12, 32'h0000_0200, 32'h1234_F678, 0, 0, 1, 32'hFFFF_F678};
        tbl[6]  = '{1, 3'd2, 5'd13, 32'h0000_0300, 32'hCAFE_BABE, 2, 1, 1, 32'hCAFE_BABE};
        tbl[7]  = '{1, 3'd3, 5'd14, 32'h0000_0304, 32'h0BAD_F00D, 0, 0, 1, 32'h0BAD_F00D};
        tbl[8]  = '{1, 3'd2, 5'd15, 32'h0000_0101, 32'hA5A5_A5A5, 0, 1, 1, 32'hA5A5_A5A5};
        tbl[9]  = '{1, 3'd2, 5'd0,  32'h0000_0400, 32'h1111_1111, 0, 1, 0, 32'h1111_1111};
        tbl[10] = '{0, 3'd0, 5'd3,  32'h1234_5678, 32'h0,         0, 0, 1, 32'h1234_5678};
        tbl[11] = '{0, 3'd0, 5'd0,  32'h0000_FFFF, 32'h0,         0, 0, 0, 32'h0000_FFFF};
        tbl[12] = '{1, 3'd4, 5'd16, 32'h0000_0103, 32'h80FF_FFFF, 4, 0, 1, 32'h0000_0080};
        tbl[13] = '{1, 3'd1, 5'd17, 32'h0000_0201, 32'h8001_AAAA, 0, 0, 1, 32'hFFFF_AAAA};

        // Reset state
        #12;
        chk("rst.req_valid", mem_req_valid, 0);
        chk("rst.req_addr", mem_req_addr, 0);
        chk("rst.we", rf_write_enable, 0);
        chk("rst.rd", rf_rd_addr, 0);
        chk("rst.data", rf_rd_data, 0);
        chk("rst.busy", busy, 0);
        chk("rst.ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            bit m;
            m = is_mis(tbl[i].is_load, tbl[i].f3, tbl[i].res);
            run_txn($sformatf("vec%0d", i), tbl[i].is_load, tbl[i].f3, tbl[i].rd, tbl[i].res,
                    tbl[i].rsp, tbl[i].stall, tbl[i].wcyc, tbl[i].we && !m, tbl[i].data);
        end

        // Back-to-back ALU writebacks
        @(negedge clk);
        in_valid = 1'b1; in_is_load = 1'b0; in_rd_addr = 5'd5; in_result = 32'h0000_1234;
        @(negedge clk);
        chk("b2b.we1", rf_write_enable, 1);
        chk("b2b.rd1", rf_rd_addr, 5);
        chk("b2b.data1", rf_rd_data, 32'h0000_1234);
        chk("b2b.ready1", in_ready, 1);
        in_rd_addr = 5'd6; in_result = 32'hDEAD_BEEF;
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b.we2", rf_write_enable, 1);
        chk("b2b.rd2", rf_rd_addr, 6);
        chk("b2b.data2", rf_rd_data, 32'hDEAD_BEEF);
        chk("b2b.ready2", in_ready, 1);
        @(negedge clk);
        chk("b2b.we_drop", rf_write_enable, 0);
        chk("b2b.idle", busy, 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            bit        ld;
            bit [2:0]  f3;
            bit [4:0]  rd;
            bit [31:0] res;
            bit [31:0] rsp;
            bit [31:0] exp;
            ld  = ($urandom % 4) != 0;
            f3  = 3'($urandom % 8);
            rd  = 5'($urandom % 32);
            res = $urandom;
            rsp = $urandom;
            exp = ld ? ref_load(f3, res, rsp) : res;
            run_txn($sformatf("rnd%0d", i), ld, f3, rd, res, rsp, int'($urandom % 4),
                    int'($urandom % 4), (rd != 0) && !is_mis(ld, f3, res), exp);
        end

        // Reset while waiting for the response, then a late response
        @(negedge clk);
        in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'd2; in_rd_addr = 5'd9;
        in_result = 32'h0000_0500;
        @(negedge clk);
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("abort.in_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort.req_valid", mem_req_valid, 0);
        chk("abort.req_addr", mem_req_addr, 0);
        chk("abort.we", rf_write_enable, 0);
        chk("abort.rd", rf_rd_addr, 0);
        chk("abort.data", rf_rd_data, 0);
        chk("abort.busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'h7777_7777;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("abort.late_we", rf_write_enable, 0);
        chk("abort.late_data", rf_rd_data, 0);
        @(negedge clk);
        chk("abort.late_we2", rf_write_enable, 0);
        chk("abort.late_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
